alloc_nw: RTL and testbench
===========================

Name: alloc_nw

Overview:
- N-wide allocation stage between rename (RA0) and the reservation stations (RS0).
- Accepts a group of up to ALLOC_WIDTH renamed uops per cycle and holds them in a group-granular skid FIFO.
- Dispatches lanes in program order, gated by RS, LDQ and STQ credits; partial-group dispatch is allowed.
- Stamps ldq/stq ids onto memory uops. Replaces the single-wide alloc and removes the combinational stall path back to rename.

Parameters:
- ALLOC_WIDTH, 2, uop lanes per group (1..4).
- SKID_DEPTH, 2, groups held in the skid FIFO (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- nuke_rb1  in  t_nuke_pkt  flush; .valid kills all held state
- valid_ra0  in  [ALLOC_WIDTH]  per-lane valid; lanes contiguous from lane 0
- uinstr_ra0  in  t_uinstr[ALLOC_WIDTH]  decoded uops
- rename_ra0  in  t_rename_pkt[ALLOC_WIDTH]  rename results
- alloc_ready_ra0  out  1  group accepted this cycle if any valid_ra0
- src_addr_ra0  out  t_gpr_id[ALLOC_WIDTH][NUM_SOURCES]  src1/src2 opreg per lane, combinational
- rs_free_rs0  in  $clog2(ALLOC_WIDTH+1)  RS entries free this cycle
- ldq_free_rs0  in  $clog2(ALLOC_WIDTH+1)  LDQ entries free this cycle
- stq_free_rs0  in  $clog2(ALLOC_WIDTH+1)  STQ entries free this cycle
- ldqid_base_rs0  in  t_ldq_id  next LDQ id to allocate
- stqid_base_rs0  in  t_stq_id  next STQ id to allocate
- disp_valid_rs0  out  [ALLOC_WIDTH]  per-lane dispatch
- disp_pkt_rs0  out  t_disp_pkt[ALLOC_WIDTH]  dispatch packets
- ldq_alloc_cnt_rs0  out  $clog2(ALLOC_WIDTH+1)  loads dispatched this cycle
- stq_alloc_cnt_rs0  out  $clog2(ALLOC_WIDTH+1)  stores dispatched this cycle

Behaviour:
Accept (RA0):
- Accept when alloc_ready_ra0 & |valid_ra0 & ~nuke_rb1.valid.
- Build a disp_pkt per lane from uinstr/rename, meta='0.
- The group, with its valid mask as its pending mask, is written to the FIFO tail at the clock edge.
- A group with a non-contiguous valid mask is an assertion error.

Ready:
- alloc_ready_ra0 = (count_q < SKID_DEPTH), driven from registered state only.
- It never depends on rs/ldq/stq inputs in the same cycle.

Dispatch (RS0), from the FIFO head only:
- Earliest dispatch is the cycle after acceptance; there is no RA0-to-RS0 bypass.
- Walk pending lanes in ascending order. A lane dispatches only if all older pending lanes in the head dispatch this cycle, and cumulative resources allow it:
  - RS: each lane uses 1 of rs_free_rs0.
  - Load (uop_is_ld): uses 1 of ldq_free_rs0.
  - Store (uop_is_st): uses 1 of stq_free_rs0.
- The walk stops at the first lane that fails.
- For ldst lanes: meta.mem.ldqid = ldqid_base_rs0 + loads dispatched in older lanes this cycle; meta.mem.stqid = stqid_base_rs0 + stores dispatched in older lanes this cycle. Sums wrap modulo the id width.
- Non-memory lanes keep meta.mem = '0.
- Dispatched lanes clear their pending bit. When the pending mask reaches 0, pop the head at the edge; the next group dispatches in the following cycle.
- ldq_alloc_cnt_rs0 / stq_alloc_cnt_rs0 = popcount of dispatched load / store lanes.

FIFO:
- Head/tail pointers are $clog2(SKID_DEPTH) bits and wrap; count_q is 0..SKID_DEPTH.
- Push and pop in the same cycle leaves count unchanged.
- A push on full is impossible by construction; assert it never happens.

Nuke:
- nuke_rb1.valid forces disp_valid_rs0=0 and the alloc counts to 0, blocks acceptance, and clears the FIFO (count, pointers, pending) at the edge.
- alloc_ready_ra0 returns to 1 the next cycle.

Reset:
- disp_valid_rs0=0, counts=0, count_q=0, pointers=0, alloc_ready_ra0=1 from the first cycle after reset.
- Reset during partial dispatch discards the group.

Simulation:
- Print a UINFO line per dispatched lane with robid, pdst, psrc1/2 and pend bits.

Test Plan:
- Single ALU group, valid=2'b11, all free=2 -> accepted cycle 0; disp_valid=2'b11 in cycle 1; counts 0; ready stays 1.
- Two loads, ldq_free=1, ldqid_base=5 -> cycle 1: lane0 dispatches ldqid 5, ldq_alloc_cnt=1. Next cycle ldq_free=1, base=6 -> lane1 dispatches ldqid 6, head pops.
- rs_free=0 for 4 cycles while 3 groups offered -> 2 accepted, ready=0 after 2. rs_free=2 -> one group per cycle drains; ready returns the cycle after the first pop; order preserved.
- Mixed group st,ld with stqid_base=3 (max id), ldqid_base=0, all free -> st gets stqid 3; ld gets ldqid 0, stqid 3+1 wrapped to 0; counts 1/1.
- Nuke with FIFO full and head partially dispatched -> no disp_valid that cycle; count=0 and ready=1 next cycle; the offered group is not accepted in the nuke cycle.
- Reset asserted mid-dispatch, then released -> all disp_valid=0 and ready=1; a fresh group dispatches in cycle 1 after acceptance.

Source files
------------

// File: rtl/alloc_nw_if.sv
// alloc_nw_pkg / alloc_nw_if
//   Shared types for the N-wide allocation stage, and the interface that
//   bundles the RA0 (rename -> alloc) and RS0 (alloc -> reservation
//   station) buses.
//
//   RA0 side : valid_ra0, uinstr_ra0, rename_ra0 in; alloc_ready_ra0 and
//              src_addr_ra0 out.
//   RS0 side : rs/ldq/stq free counts and ldq/stq id bases in;
//              disp_valid_rs0, disp_pkt_rs0 and the ldq/stq alloc counts out.
//   Modports : slave = the allocation stage, master = its environment.

package alloc_nw_pkg;

  localparam int NUM_SOURCES = 2;
  localparam int GPR_ID_W    = 5;
  localparam int PREG_ID_W   = 7;
  localparam int ROB_ID_W    = 6;
  localparam int LDQ_ID_W    = 3;
  localparam int STQ_ID_W    = 2;

  typedef logic [GPR_ID_W-1:0]  t_gpr_id;
  typedef logic [PREG_ID_W-1:0] t_preg_id;
  typedef logic [ROB_ID_W-1:0]  t_rob_id;
  typedef logic [LDQ_ID_W-1:0]  t_ldq_id;
  typedef logic [STQ_ID_W-1:0]  t_stq_id;

  typedef struct packed {
    logic [7:0] opcode;
    t_gpr_id    dst;
    t_gpr_id    src1;
    t_gpr_id    src2;
    logic       uop_is_ld;
    logic       uop_is_st;
  } t_uinstr;

  typedef struct packed {
    t_rob_id  robid;
    t_preg_id pdst;
    t_preg_id psrc1;
    t_preg_id psrc2;
    logic     psrc1_pend;
    logic     psrc2_pend;
  } t_rename_pkt;

  // Flush from the retire stage; only the strobe matters to allocation.
  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    t_ldq_id ldqid;
    t_stq_id stqid;
  } t_mem_meta;

  typedef struct packed {
    t_mem_meta mem;
  } t_meta;

  typedef struct packed {
    t_uinstr     uinstr;
    t_rename_pkt rename;
    t_meta       meta;
  } t_disp_pkt;

endpackage

interface alloc_nw_if #(
  parameter int ALLOC_WIDTH = 2
);
  import alloc_nw_pkg::*;

  localparam int CNT_W = $clog2(ALLOC_WIDTH + 1);

  // RA0
  logic        [ALLOC_WIDTH-1:0]                  valid_ra0;
  t_uinstr     [ALLOC_WIDTH-1:0]                  uinstr_ra0;
  t_rename_pkt [ALLOC_WIDTH-1:0]                  rename_ra0;
  logic                                           alloc_ready_ra0;
  t_gpr_id     [ALLOC_WIDTH-1:0][NUM_SOURCES-1:0] src_addr_ra0;

  // RS0
  logic        [CNT_W-1:0]                        rs_free_rs0;
  logic        [CNT_W-1:0]                        ldq_free_rs0;
  logic        [CNT_W-1:0]                        stq_free_rs0;
  t_ldq_id                                        ldqid_base_rs0;
  t_stq_id                                        stqid_base_rs0;
  logic        [ALLOC_WIDTH-1:0]                  disp_valid_rs0;
  t_disp_pkt   [ALLOC_WIDTH-1:0]                  disp_pkt_rs0;
  logic        [CNT_W-1:0]                        ldq_alloc_cnt_rs0;
  logic        [CNT_W-1:0]                        stq_alloc_cnt_rs0;

  modport slave (
    input  valid_ra0, uinstr_ra0, rename_ra0,
    input  rs_free_rs0, ldq_free_rs0, stq_free_rs0,
    input  ldqid_base_rs0, stqid_base_rs0,
    output alloc_ready_ra0, src_addr_ra0,
    output disp_valid_rs0, disp_pkt_rs0,
    output ldq_alloc_cnt_rs0, stq_alloc_cnt_rs0
  );

  modport master (
    output valid_ra0, uinstr_ra0, rename_ra0,
    output rs_free_rs0, ldq_free_rs0, stq_free_rs0,
    output ldqid_base_rs0, stqid_base_rs0,
    input  alloc_ready_ra0, src_addr_ra0,
    input  disp_valid_rs0, disp_pkt_rs0,
    input  ldq_alloc_cnt_rs0, stq_alloc_cnt_rs0
  );

endinterface

// File: rtl/alloc_nw.sv
// alloc_nw
//   N-wide allocation stage between rename (RA0) and the reservation
//   stations (RS0). Whole rename groups are captured into a small
//   group-granular skid FIFO; lanes of the head group dispatch in program
//   order as RS/LDQ/STQ credits allow, possibly over several cycles. Memory
//   uops are stamped with ldq/stq ids at dispatch. alloc_ready_ra0 comes
//   from FIFO occupancy only, so rename never sees a combinational stall
//   path from the RS0 credit inputs.
//
//   clk      : clock
//   reset    : synchronous active-high reset
//   nuke_rb1 : flush; .valid kills every held group and masks dispatch
//   alloc_if : alloc_nw_if.slave, RA0 and RS0 buses

module alloc_nw
  import alloc_nw_pkg::*;
#(
  parameter int ALLOC_WIDTH = 2,
  parameter int SKID_DEPTH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  t_nuke_pkt        nuke_rb1,
  alloc_nw_if.slave        alloc_if
);

  localparam int CNT_W = $clog2(ALLOC_WIDTH + 1);
  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  typedef logic [ALLOC_WIDTH-1:0] t_lane_mask;
  typedef t_disp_pkt [ALLOC_WIDTH-1:0] t_group;

  // FIFO state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  t_lane_mask       pend_q [SKID_DEPTH];
  t_group           grp_q  [SKID_DEPTH];

  logic       accept;
  logic       pop;
  logic       head_vld;
  t_lane_mask head_pend;
  t_lane_mask pend_next;
  t_lane_mask valid_contig;
  t_group     in_grp;

  // ---------------------------------------------------------------- RA0
  assign alloc_if.alloc_ready_ra0 = (count_q < OCC_W'(SKID_DEPTH));
  assign accept = alloc_if.alloc_ready_ra0 & (|alloc_if.valid_ra0) & ~nuke_rb1.valid;

  always_comb begin
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      in_grp[i].uinstr              = alloc_if.uinstr_ra0[i];
      in_grp[i].rename              = alloc_if.rename_ra0[i];
      in_grp[i].meta                = '0;
      alloc_if.src_addr_ra0[i][0]   = alloc_if.uinstr_ra0[i].src1;
      alloc_if.src_addr_ra0[i][1]   = alloc_if.uinstr_ra0[i].src2;
    end
  end

  // ---------------------------------------------------------------- RS0
  assign head_vld  = (count_q != '0);
  assign head_pend = pend_q[head_q];

  logic [CNT_W-1:0] rs_used, ld_used, st_used;
  logic             walk_ok;
  logic             is_ld, is_st;

  // NOTE: every output of this block gets a default before the walk so no
  // path leaves a variable unassigned and no latch is inferred. Blocking
  // assignments are intentional: the running credit totals must be visible
  // to the next lane within the same evaluation.
  always_comb begin
    alloc_if.disp_valid_rs0 = '0;
    alloc_if.disp_pkt_rs0   = grp_q[head_q];
    rs_used = '0;
    ld_used = '0;
    st_used = '0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    walk_ok = head_vld & ~nuke_rb1.valid & ~reset;

    // In-order walk: already-dispatched lanes are skipped; the first lane
    // that lacks a credit stops all younger lanes.
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      is_ld = grp_q[head_q][i].uinstr.uop_is_ld;
      is_st = grp_q[head_q][i].uinstr.uop_is_st;
      if (walk_ok && head_pend[i]) begin
        if ((rs_used + CNT_W'(1))     <= alloc_if.rs_free_rs0  &&
            (ld_used + CNT_W'(is_ld)) <= alloc_if.ldq_free_rs0 &&
            (st_used + CNT_W'(is_st)) <= alloc_if.stq_free_rs0) begin
          alloc_if.disp_valid_rs0[i] = 1'b1;
          if (is_ld || is_st) begin
            // Ids are offsets from the queue's next free id; the sum wraps.
            alloc_if.disp_pkt_rs0[i].meta.mem.ldqid =
              alloc_if.ldqid_base_rs0 + LDQ_ID_W'(ld_used);
            alloc_if.disp_pkt_rs0[i].meta.mem.stqid =
              alloc_if.stqid_base_rs0 + STQ_ID_W'(st_used);
          end
          rs_used = rs_used + CNT_W'(1);
          ld_used = ld_used + CNT_W'(is_ld);
          st_used = st_used + CNT_W'(is_st);
        end else begin
          walk_ok = 1'b0;
        end
      end
    end

    alloc_if.ldq_alloc_cnt_rs0 = ld_used;
    alloc_if.stq_alloc_cnt_rs0 = st_used;
  end

  // ---------------------------------------------------------------- FIFO
  assign pend_next = head_pend & ~alloc_if.disp_valid_rs0;
  assign pop       = (|alloc_if.disp_valid_rs0) & (pend_next == '0);

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(accept);
    count_d = count_q + OCC_W'(accept) - OCC_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || nuke_rb1.valid) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < SKID_DEPTH; s++) pend_q[s] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Head and tail coincide only when empty (no head update) or full
      // (no push), so these two writes never target the same slot.
      if (|alloc_if.disp_valid_rs0) pend_q[head_q] <= pend_next;
      if (accept)                   pend_q[tail_q] <= alloc_if.valid_ra0;
    end
  end

  // NOTE: the group payload is deliberately not reset; a slot is only read
  // while its pending mask is non-zero, and that mask is always cleared.
  always_ff @(posedge clk) begin
    if (accept) grp_q[tail_q] <= in_grp;
  end

  // ---------------------------------------------------------------- checks
  assign valid_contig = alloc_if.valid_ra0 & (alloc_if.valid_ra0 + t_lane_mask'(1));

  a_valid_contiguous: assert property (@(posedge clk) disable iff (reset)
    (|alloc_if.valid_ra0) |-> (valid_contig == '0));

  a_no_push_on_full: assert property (@(posedge clk) disable iff (reset)
    !(accept && (count_q == OCC_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_alloc_nw.sv
// tb_alloc_nw
//   Directed bench for alloc_nw (ALLOC_WIDTH=2, SKID_DEPTH=2). The stimulus
//   thread pushes the hand-computed dispatch expected from each accepted
//   group into a scoreboard; a negedge monitor pops one entry per cycle in
//   which any lane dispatches and compares mask, packets and alloc counts.

module tb_alloc_nw;
  import alloc_nw_pkg::*;

  localparam int W = 2;
  localparam int D = 2;

  logic      clk;
  logic      reset;
  t_nuke_pkt nuke_rb1;

  alloc_nw_if #(.ALLOC_WIDTH(W)) bus ();

  alloc_nw #(.ALLOC_WIDTH(W), .SKID_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .nuke_rb1 (nuke_rb1),
    .alloc_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]              mask;
    t_disp_pkt [W-1:0]         pkt;
    logic [1:0]                ld_cnt;
    logic [1:0]                st_cnt;
  } t_exp;

  t_exp sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Uop n gets recognisable field values derived from n.
  function automatic t_uinstr mk_ui(input bit ld, input bit st, input int n);
    t_uinstr u;
    u.opcode    = 8'(n);
    u.dst       = t_gpr_id'(n);
    u.src1      = t_gpr_id'(n + 1);
    u.src2      = t_gpr_id'(n + 2);
    u.uop_is_ld = ld;
    u.uop_is_st = st;
    return u;
  endfunction

  function automatic t_rename_pkt mk_rn(input int n);
    t_rename_pkt r;
    r.robid      = t_rob_id'(n);
    r.pdst       = t_preg_id'(n + 32);
    r.psrc1      = t_preg_id'(n + 40);
    r.psrc2      = t_preg_id'(n + 50);
    r.psrc1_pend = n[0];
    r.psrc2_pend = n[1];
    return r;
  endfunction

  function automatic t_disp_pkt exp_pkt(input bit ld, input bit st, input int n,
                                        input int lid, input int sid);
    t_disp_pkt p;
    p.uinstr          = mk_ui(ld, st, n);
    p.rename          = mk_rn(n);
    p.meta.mem.ldqid  = t_ldq_id'(lid);
    p.meta.mem.stqid  = t_stq_id'(sid);
    return p;
  endfunction

  task automatic push_exp(input logic [W-1:0] mask, input t_disp_pkt p0, input t_disp_pkt p1,
                          input logic [1:0] ldc, input logic [1:0] stc);
    t_exp e;
    e.mask   = mask;
    e.pkt[0] = p0;
    e.pkt[1] = p1;
    e.ld_cnt = ldc;
    e.st_cnt = stc;
    sb_q.push_back(e);
  endtask

  task automatic offer(input logic [W-1:0] v,
                       input bit ld0, input bit st0, input int n0,
                       input bit ld1, input bit st1, input int n1);
    bus.valid_ra0     = v;
    bus.uinstr_ra0[0] = mk_ui(ld0, st0, n0);
    bus.rename_ra0[0] = mk_rn(n0);
    bus.uinstr_ra0[1] = mk_ui(ld1, st1, n1);
    bus.rename_ra0[1] = mk_rn(n1);
  endtask

  task automatic set_free(input int rs, input int ldq, input int stq);
    bus.rs_free_rs0  = 2'(rs);
    bus.ldq_free_rs0 = 2'(ldq);
    bus.stq_free_rs0 = 2'(stq);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (|bus.disp_valid_rs0) begin
        for (int i = 0; i < W; i++) begin
          if (bus.disp_valid_rs0[i])
            $display("UINFO lane %0d robid %0d pdst %0d psrc1 %0d psrc2 %0d pend %b%b",
                     i, bus.disp_pkt_rs0[i].rename.robid, bus.disp_pkt_rs0[i].rename.pdst,
                     bus.disp_pkt_rs0[i].rename.psrc1, bus.disp_pkt_rs0[i].rename.psrc2,
                     bus.disp_pkt_rs0[i].rename.psrc1_pend, bus.disp_pkt_rs0[i].rename.psrc2_pend);
        end
        if (sb_q.size() == 0) begin
          check("sb_unexpected_disp", 64'(bus.disp_valid_rs0), 64'd0);
        end else begin
          t_exp e;
          e = sb_q.pop_front();
          check("sb_mask", 64'(bus.disp_valid_rs0), 64'(e.mask));
          for (int i = 0; i < W; i++) begin
            if (e.mask[i])
              check($sformatf("sb_pkt_lane%0d", i), 64'(bus.disp_pkt_rs0[i]), 64'(e.pkt[i]));
          end
          check("sb_ld_cnt", 64'(bus.ldq_alloc_cnt_rs0), 64'(e.ld_cnt));
          check("sb_st_cnt", 64'(bus.stq_alloc_cnt_rs0), 64'(e.st_cnt));
        end
      end else begin
        check("idle_ld_cnt", 64'(bus.ldq_alloc_cnt_rs0), 64'd0);
        check("idle_st_cnt", 64'(bus.stq_alloc_cnt_rs0), 64'd0);
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    t_disp_pkt z;
    z = '0;
    reset          = 1'b1;
    nuke_rb1       = '0;
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    set_free(2, 2, 2);
    bus.ldqid_base_rs0 = '0;
    bus.stqid_base_rs0 = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.alloc_ready_ra0), 64'd1);
    check("rst_disp", 64'(bus.disp_valid_rs0), 64'd0);

    // T1: single ALU group, all credits available.
    next_cycle();
    offer(2'b11, 0, 0, 1, 0, 0, 2);
    @(negedge clk);
    check("t1_ready", 64'(bus.alloc_ready_ra0), 64'd1);
    check("t1_no_bypass", 64'(bus.disp_valid_rs0), 64'd0);
    check("t1_src1_l0", 64'(bus.src_addr_ra0[0][0]), 64'd2);
    check("t1_src2_l1", 64'(bus.src_addr_ra0[1][1]), 64'd4);
    push_exp(2'b11, exp_pkt(0, 0, 1, 0, 0), exp_pkt(0, 0, 2, 0, 0), 0, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_disp", 64'(bus.disp_valid_rs0), 64'd3);
    check("t1_ready_c1", 64'(bus.alloc_ready_ra0), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t1_drained", 64'(bus.disp_valid_rs0), 64'd0);

    // T2: two loads, one LDQ credit per cycle.
    next_cycle();
    offer(2'b11, 1, 0, 3, 1, 0, 4);
    @(negedge clk);
    check("t2_ready", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b01, exp_pkt(1, 0, 3, 5, 0), z, 1, 0);
    push_exp(2'b10, z, exp_pkt(1, 0, 4, 6, 0), 1, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    set_free(2, 1, 2);
    bus.ldqid_base_rs0 = 3'd5;
    @(negedge clk);
    check("t2_disp_l0", 64'(bus.disp_valid_rs0), 64'd1);
    next_cycle();
    bus.ldqid_base_rs0 = 3'd6;
    @(negedge clk);
    check("t2_disp_l1", 64'(bus.disp_valid_rs0), 64'd2);
    next_cycle();
    set_free(2, 2, 2);
    bus.ldqid_base_rs0 = '0;
    @(negedge clk);
    check("t2_popped", 64'(bus.disp_valid_rs0), 64'd0);

    // T3: RS backpressure fills the FIFO; drain preserves order.
    next_cycle();
    set_free(0, 2, 2);
    offer(2'b11, 0, 0, 10, 0, 0, 11);
    @(negedge clk);
    check("t3_acc_g1", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b11, exp_pkt(0, 0, 10, 0, 0), exp_pkt(0, 0, 11, 0, 0), 0, 0);
    next_cycle();
    offer(2'b11, 0, 0, 12, 0, 0, 13);
    @(negedge clk);
    check("t3_acc_g2", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b11, exp_pkt(0, 0, 12, 0, 0), exp_pkt(0, 0, 13, 0, 0), 0, 0);
    next_cycle();
    offer(2'b11, 0, 0, 14, 0, 0, 15);
    @(negedge clk);
    check("t3_full_a", 64'(bus.alloc_ready_ra0), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t3_full_b", 64'(bus.alloc_ready_ra0), 64'd0);
    check("t3_no_credit", 64'(bus.disp_valid_rs0), 64'd0);
    next_cycle();
    set_free(2, 2, 2);
    @(negedge clk);
    check("t3_ready_pre_pop", 64'(bus.alloc_ready_ra0), 64'd0);
    check("t3_disp_g1", 64'(bus.disp_valid_rs0), 64'd3);
    next_cycle();
    @(negedge clk);
    check("t3_ready_post_pop", 64'(bus.alloc_ready_ra0), 64'd1);
    check("t3_disp_g2", 64'(bus.disp_valid_rs0), 64'd3);
    push_exp(2'b11, exp_pkt(0, 0, 14, 0, 0), exp_pkt(0, 0, 15, 0, 0), 0, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_disp_g3", 64'(bus.disp_valid_rs0), 64'd3);
    next_cycle();
    @(negedge clk);
    check("t3_empty", 64'(bus.disp_valid_rs0), 64'd0);

    // T4: store then load, STQ id wraps from max.
    next_cycle();
    bus.stqid_base_rs0 = 2'd3;
    bus.ldqid_base_rs0 = 3'd0;
    offer(2'b11, 0, 1, 20, 1, 0, 21);
    @(negedge clk);
    check("t4_ready", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b11, exp_pkt(0, 1, 20, 0, 3), exp_pkt(1, 0, 21, 0, 0), 1, 1);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_disp", 64'(bus.disp_valid_rs0), 64'd3);
    next_cycle();
    bus.stqid_base_rs0 = '0;

    // T5: nuke with FIFO full and head partially dispatched.
    set_free(1, 2, 2);
    offer(2'b11, 0, 0, 30, 0, 0, 31);
    @(negedge clk);
    check("t5_acc_a", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b01, exp_pkt(0, 0, 30, 0, 0), z, 0, 0);
    next_cycle();
    offer(2'b11, 0, 0, 32, 0, 0, 33);
    @(negedge clk);
    check("t5_acc_b", 64'(bus.alloc_ready_ra0), 64'd1);
    check("t5_partial", 64'(bus.disp_valid_rs0), 64'd1);
    next_cycle();
    nuke_rb1.valid = 1'b1;
    offer(2'b11, 0, 0, 34, 0, 0, 35);
    @(negedge clk);
    check("t5_nuke_disp", 64'(bus.disp_valid_rs0), 64'd0);
    check("t5_nuke_ldc", 64'(bus.ldq_alloc_cnt_rs0), 64'd0);
    next_cycle();
    nuke_rb1.valid = 1'b0;
    set_free(2, 2, 2);
    @(negedge clk);
    check("t5_ready_after", 64'(bus.alloc_ready_ra0), 64'd1);
    check("t5_flushed", 64'(bus.disp_valid_rs0), 64'd0);
    push_exp(2'b11, exp_pkt(0, 0, 34, 0, 0), exp_pkt(0, 0, 35, 0, 0), 0, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_disp_c", 64'(bus.disp_valid_rs0), 64'd3);
    next_cycle();
    @(negedge clk);
    check("t5_empty", 64'(bus.disp_valid_rs0), 64'd0);

    // T6: reset in the middle of a partial dispatch.
    next_cycle();
    set_free(1, 2, 2);
    offer(2'b11, 0, 0, 40, 0, 0, 41);
    @(negedge clk);
    check("t6_acc_d", 64'(bus.alloc_ready_ra0), 64'd1);
    push_exp(2'b01, exp_pkt(0, 0, 40, 0, 0), z, 0, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t6_partial", 64'(bus.disp_valid_rs0), 64'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_disp", 64'(bus.disp_valid_rs0), 64'd0);
    next_cycle();
    reset = 1'b0;
    set_free(2, 2, 2);
    offer(2'b11, 0, 0, 42, 0, 0, 43);
    @(negedge clk);
    check("t6_ready", 64'(bus.alloc_ready_ra0), 64'd1);
    check("t6_discarded", 64'(bus.disp_valid_rs0), 64'd0);
    push_exp(2'b11, exp_pkt(0, 0, 42, 0, 0), exp_pkt(0, 0, 43, 0, 0), 0, 0);
    next_cycle();
    offer(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t6_disp_e", 64'(bus.disp_valid_rs0), 64'd3);
    next_cycle();
    @(negedge clk);
    check("t6_empty", 64'(bus.disp_valid_rs0), 64'd0);

    repeat (2) next_cycle();
    @(negedge clk);
    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
